// File: rtl/dff_pipeline_if.sv
// Handshake bundle for dff_pipeline: producer side, consumer side, flush and occupancy.
// The master modport is the block driving the pipeline, the slave modport is the pipeline itself.
interface dff_pipeline_if #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [CW-1:0]    count;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/dff_pipeline.sv
// WIDTH x DEPTH register pipeline with valid/ready flow control.
// Empty stages keep absorbing data while the output is stalled, so bubbles collapse.
module dff_pipeline #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic           clk,
   input logic           rst_n,
   dff_pipeline_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [CW-1:0]    r_count;

   logic [DEPTH-1:0] w_rdy;
   logic [DEPTH-1:0] w_up_valid;
   logic [WIDTH-1:0] w_up_data [DEPTH];
   logic             w_in_xfer;
   logic             w_out_xfer;

   // A stage can load when any stage at or beyond it is empty, or the consumer takes the head.
   always_comb begin
      w_rdy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_rdy[i] = bus.out_ready;
         for (int j = i; j < DEPTH; j++) begin
            w_rdy[i] = w_rdy[i] | ~r_valid[j];
         end
      end
   end

   always_comb begin
      w_up_valid    = '0;
      w_up_valid[0] = bus.in_valid;
      w_up_data[0]  = bus.in_data;
      for (int i = 1; i < DEPTH; i++) begin
         w_up_valid[i] = r_valid[i-1];
         w_up_data[i]  = r_data[i-1];
      end
   end

   // NOTE: in_ready is gated by rst_n so nothing is offered acceptance while reset is held.
   assign bus.in_ready  = w_rdy[0] & ~bus.flush & rst_n;
   assign bus.out_valid = r_valid[DEPTH-1];
   assign bus.out_data  = r_data[DEPTH-1];
   assign bus.count     = r_count;

   assign w_in_xfer  = bus.in_valid & bus.in_ready;
   assign w_out_xfer = r_valid[DEPTH-1] & bus.out_ready;

   // NOTE: the data array is reset as well, because out_data must read RST_VAL during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= RST_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_rdy[i]) begin
               r_valid[i] <= w_up_valid[i];
               if (w_up_valid[i] && !bus.flush) begin
                  r_data[i] <= w_up_data[i];
               end
            end
         end

         if (bus.flush) begin
            r_valid <= '0;
            r_count <= '0;
         end else if (w_in_xfer && !w_out_xfer) begin
            r_count <= r_count + CW'(1);
         end else if (!w_in_xfer && w_out_xfer) begin
            r_count <= r_count - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_dff_pipeline.sv
// Self-checking bench for dff_pipeline (WIDTH=3, DEPTH=4): directed scenarios plus a random run
// compared against a queue model that tracks each item's stage position.
module tb_dff_pipeline;
   localparam int WIDTH = 3;
   localparam int DEPTH = 4;

   typedef struct {
      logic [WIDTH-1:0] d;
      int               pos;
   } item_t;

   logic  clk;
   logic  rst_n;
   int    n_tests;
   int    n_fail;
   item_t mq[$];

   dff_pipeline_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   dff_pipeline #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .RST_VAL(3'd0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the inputs currently on the bus. Items move one stage per cycle
   // when a hole lies ahead of them or the consumer is taking data; the head leaves on out_ready.
   task automatic step();
      bit               exp_rdy, exp_ov, acc, emit, o_rdy, fl;
      logic [WIDTH-1:0] d_in;
      item_t            it;
      item_t            nq[$];
      #1;
      exp_rdy = !bus.flush && (mq.size() < DEPTH || bus.out_ready);
      exp_ov  = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      chk("count", {29'd0, bus.count}, mq.size());
      if (exp_ov) chk("out_data", {29'd0, bus.out_data}, {29'd0, mq[0].d});
      o_rdy = bus.out_ready;
      fl    = bus.flush;
      d_in  = bus.in_data;
      acc   = bus.in_valid && exp_rdy;
      emit  = exp_ov && o_rdy;
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
      end else begin
         for (int j = 0; j < mq.size(); j++) begin
            if (j == 0 && emit) continue;
            it = mq[j];
            if (o_rdy || (DEPTH - 1 - it.pos > j)) it.pos++;
            nq.push_back(it);
         end
         if (acc) nq.push_back('{d: d_in, pos: 0});
         mq = nq;
      end
   endtask

   task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit o_rdy, input bit fl);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = o_rdy;
      bus.flush     = fl;
      step();
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;

      // Reset state while rst_n is held low
      #3;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_count", {29'd0, bus.count}, 32'd0);
      chk("rst_out_data", {29'd0, bus.out_data}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back stream with the consumer always ready: 4-cycle latency, 1 item/cycle
      drive(1, 3'd4, 1, 0);
      drive(1, 3'd2, 1, 0);
      drive(1, 3'd3, 1, 0);
      drive(1, 3'd6, 1, 0);
      for (int i = 0; i < 6; i++) drive(0, 3'd0, 1, 0);

      // Stalled output: fifth item refused until the consumer resumes
      for (int i = 1; i <= 4; i++) drive(1, 3'(i), 0, 0);
      drive(1, 3'd5, 0, 0);
      drive(1, 3'd5, 0, 0);
      chk("full_count", {29'd0, bus.count}, 32'd4);
      drive(1, 3'd5, 1, 0);
      for (int i = 0; i < 7; i++) drive(0, 3'd0, 1, 0);

      // Gap between two items collapses while stalled
      drive(1, 3'd1, 0, 0);
      drive(0, 3'd0, 0, 0);
      drive(0, 3'd0, 0, 0);
      drive(1, 3'd7, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 3'd0, 0, 0);
      chk("gap_count", {29'd0, bus.count}, 32'd2);
      for (int i = 0; i < 4; i++) drive(0, 3'd0, 1, 0);

      // Flush with an item offered in the same cycle: the offered item is discarded
      for (int i = 1; i <= 3; i++) drive(1, 3'(i), 0, 0);
      drive(1, 3'd5, 0, 1);
      chk("flush_count", {29'd0, bus.count}, 32'd0);
      for (int i = 0; i < 6; i++) drive(0, 3'd0, 1, 0);

      // Asynchronous reset mid-stream with three items held
      for (int i = 1; i <= 3; i++) drive(1, 3'(i + 2), 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 3'd0, 0, 0);
      chk("pre_rst_count", {29'd0, bus.count}, 32'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("async_count", {29'd0, bus.count}, 32'd0);
      chk("async_out_data", {29'd0, bus.out_data}, 32'd0);
      chk("async_in_ready", {31'd0, bus.in_ready}, 32'd0);
      mq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full pipe, simultaneous accept and emit every cycle
      for (int i = 0; i < 6; i++) drive(1, 3'($urandom_range(7)), 0, 0);
      for (int i = 0; i < 10; i++) begin
         drive(1, 3'($urandom_range(7)), 1, 0);
         chk("steady_count", {29'd0, bus.count}, 32'd4);
      end
      for (int i = 0; i < 6; i++) drive(0, 3'd0, 1, 0);

      // Random valid/ready/flush traffic against the queue model
      for (int i = 0; i < 800; i++) begin
         drive(1'($urandom_range(1)), 3'($urandom_range(7)),
               $urandom_range(3) != 0 ? 1'b1 : 1'b0,
               $urandom_range(40) == 0 ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < 8; i++) drive(0, 3'd0, 1, 0);
      chk("drained_count", {29'd0, bus.count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
